// File: rtl/cfu_l2_switch_pkg.sv
// Shared types, constants and parameter checks for the CFU-LI level-2 switch.
// Used by cfu_l2_switch (optional response skid register: CFU_SWITCH_RESP_REG_EN).
package cfu_l2_switch_pkg;

    localparam logic [23:0] CFU_LI_VERSION_REQ = 24'h01_00_00;
    localparam int          CFU_STATUS_W       = 3;

    // Response status codes returned on resp_status
    typedef enum logic [CFU_STATUS_W-1:0] {
        CFU_OK           = 3'd0,
        CFU_ERROR_CFU    = 3'd1,
        CFU_ERROR_OFF    = 3'd2,
        CFU_ERROR_STATE  = 3'd3,
        CFU_ERROR_INSN   = 3'd4,
        CFU_ERROR_FUNC   = 3'd5,
        CFU_ERROR_OP     = 3'd6,
        CFU_ERROR_CUSTOM = 3'd7
    } cfu_status_t;

    // Order-FIFO entry: err=1 marks a locally answered (bad CFU ID) request
    typedef struct packed {
        logic        err;
        logic [15:0] id;
    } cfu_switch_entry_t;

    // Width of an index into n items, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Elaboration-time sanity check of the L2 interface parameters
    function automatic bit check_cfu_l2_params(
        input logic [23:0] version,
        input int          n_cfus,
        input int          n_states,
        input int          cfu_id_w,
        input int          state_id_w,
        input int          func_id_w,
        input int          insn_w,
        input int          data_w
    );
        bit ok;
        ok = 1'b1;
        if (version != CFU_LI_VERSION_REQ)                    ok = 1'b0;
        if (n_cfus < 1 || n_states < 1)                       ok = 1'b0;
        if (cfu_id_w < clog2_min1(n_cfus) || cfu_id_w > 16)   ok = 1'b0;
        if (state_id_w < clog2_min1(n_states))                ok = 1'b0;
        if (func_id_w < 1 || insn_w < 1)                      ok = 1'b0;
        if (data_w != 32 && data_w != 64)                     ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/cfu_l2_switch_tag_fifo.sv
// cfu_tag_fifo: small synchronous FIFO holding the order tags of in-flight requests.
// Head entry is visible combinationally on dout so the response mux has zero latency.
module cfu_tag_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = clk_en && push && !full;
    assign do_pop  = clk_en && pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Tag storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy; both pointers wrap at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/cfu_l2_switch.sv
// CFU-LI level-2 switch: one upstream port fanned out to CFU_N_CFUS channels, responses
// returned upstream in request order. Out-of-range CFU IDs are answered with CFU_ERROR_CFU.
// Optional feature macro: CFU_SWITCH_RESP_REG_EN adds a 2-entry skid register on the
// upstream response path (+1 cycle latency, full throughput).
module cfu_l2_switch
    import cfu_l2_switch_pkg::*;
#(
    parameter logic [23:0] CFU_LI_VERSION = 24'h01_00_00,
    parameter int CFU_N_CFUS     = 4,
    parameter int CFU_N_STATES   = 1,
    parameter int CFU_CFU_ID_W   = (CFU_N_CFUS > 1) ? $clog2(CFU_N_CFUS) : 1,
    parameter int CFU_STATE_ID_W = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1,
    parameter int CFU_FUNC_ID_W  = 10,
    parameter int CFU_INSN_W     = 32,
    parameter int CFU_DATA_W     = 32,
    parameter int N_OUTSTANDING  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clk_en,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [CFU_CFU_ID_W-1:0]            req_cfu,
    input  logic [CFU_STATE_ID_W-1:0]          req_state,
    input  logic [CFU_FUNC_ID_W-1:0]           req_func,
    input  logic [CFU_INSN_W-1:0]              req_insn,
    input  logic [CFU_DATA_W-1:0]              req_data0,
    input  logic [CFU_DATA_W-1:0]              req_data1,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [CFU_STATUS_W-1:0]            resp_status,
    output logic [CFU_DATA_W-1:0]              resp_data,
    output logic [CFU_N_CFUS-1:0]              cfus_req_valid,
    input  logic [CFU_N_CFUS-1:0]              cfus_req_ready,
    output logic [CFU_STATE_ID_W-1:0]          cfus_req_state,
    output logic [CFU_FUNC_ID_W-1:0]           cfus_req_func,
    output logic [CFU_INSN_W-1:0]              cfus_req_insn,
    output logic [CFU_DATA_W-1:0]              cfus_req_data0,
    output logic [CFU_DATA_W-1:0]              cfus_req_data1,
    input  logic [CFU_N_CFUS-1:0]              cfus_resp_valid,
    output logic [CFU_N_CFUS-1:0]              cfus_resp_ready,
    input  logic [CFU_N_CFUS*CFU_STATUS_W-1:0] cfus_resp_status,
    input  logic [CFU_N_CFUS*CFU_DATA_W-1:0]   cfus_resp_data
);

    localparam int ENTRY_W = $bits(cfu_switch_entry_t);

    // Elaboration-time parameter checks
    if (!check_cfu_l2_params(CFU_LI_VERSION, CFU_N_CFUS, CFU_N_STATES, CFU_CFU_ID_W,
                             CFU_STATE_ID_W, CFU_FUNC_ID_W, CFU_INSN_W, CFU_DATA_W)) begin : g_bad_params
        $fatal(1, "cfu_l2_switch: invalid CFU-LI L2 parameter set");
    end
    if (N_OUTSTANDING < 2 || (N_OUTSTANDING & (N_OUTSTANDING - 1)) != 0) begin : g_bad_depth
        $fatal(1, "cfu_l2_switch: N_OUTSTANDING must be a power of 2 and >= 2");
    end

    // Handshakes only happen while enabled and out of reset
    logic en;
    assign en = clk_en && !rst;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                    id_valid;
    logic [CFU_N_CFUS-1:0]   req_sel;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    cfu_switch_entry_t       push_entry;
    cfu_switch_entry_t       head;
    logic [ENTRY_W-1:0]      fifo_dout;

    assign id_valid = (int'(req_cfu) < CFU_N_CFUS);

    for (genvar gi = 0; gi < CFU_N_CFUS; gi++) begin : g_req_dec
        assign req_sel[gi] = (int'(req_cfu) == gi);
    end

    // Bad IDs need no downstream channel, only room in the order FIFO
    assign req_ready      = en && !fifo_full && (id_valid ? |(req_sel & cfus_req_ready) : 1'b1);
    assign cfus_req_valid = (en && req_valid && !fifo_full) ? req_sel : '0;
    assign push           = req_valid && req_ready;

    assign cfus_req_state = req_state;
    assign cfus_req_func  = req_func;
    assign cfus_req_insn  = req_insn;
    assign cfus_req_data0 = req_data0;
    assign cfus_req_data1 = req_data1;

    // Order tag for the request being accepted
    always_comb begin
        push_entry     = '0;
        push_entry.err = !id_valid;
        if (id_valid) begin
            push_entry.id = 16'(req_cfu);
        end
    end

    cfu_tag_fifo #(
        .W     (ENTRY_W),
        .DEPTH (N_OUTSTANDING)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .push   (push),
        .pop    (pop),
        .din    (push_entry),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head = cfu_switch_entry_t'(fifo_dout);

    // ------------------------------------------------------------------
    // Response mux: only the channel named by the head tag may respond
    // ------------------------------------------------------------------
    logic [CFU_N_CFUS-1:0]   resp_sel;
    logic                    core_valid;
    logic                    core_ready;
    logic [CFU_STATUS_W-1:0] core_status;
    logic [CFU_DATA_W-1:0]   core_data;

    for (genvar gi = 0; gi < CFU_N_CFUS; gi++) begin : g_resp_dec
        assign resp_sel[gi] = !fifo_empty && !head.err && (head.id == 16'(gi));
    end

    // Select the head response; bad-ID entries answer immediately with an error
    always_comb begin
        core_valid  = 1'b0;
        core_status = CFU_OK;
        core_data   = '0;
        if (!fifo_empty) begin
            if (head.err) begin
                core_valid  = 1'b1;
                core_status = CFU_ERROR_CFU;
            end else begin
                for (int i = 0; i < CFU_N_CFUS; i++) begin
                    if (resp_sel[i]) begin
                        core_valid  = cfus_resp_valid[i];
                        core_status = cfus_resp_status[i*CFU_STATUS_W +: CFU_STATUS_W];
                        core_data   = cfus_resp_data[i*CFU_DATA_W +: CFU_DATA_W];
                    end
                end
            end
        end
    end

    assign cfus_resp_ready = core_ready ? resp_sel : '0;

`ifdef CFU_SWITCH_RESP_REG_EN
    // Two-slot skid buffer: the head is popped when its response is loaded here
    localparam int SKID_W = CFU_STATUS_W + CFU_DATA_W;

    logic [SKID_W-1:0] skid_reg [2];
    logic              skid_wr_reg;
    logic              skid_rd_reg;
    logic [1:0]        skid_cnt_reg;
    logic              skid_load;
    logic              skid_unload;

    assign core_ready  = en && (skid_cnt_reg != 2'd2);
    assign skid_load   = core_valid && core_ready;
    assign skid_unload = en && (skid_cnt_reg != 2'd0) && resp_ready;
    assign pop         = skid_load;

    assign resp_valid  = en && (skid_cnt_reg != 2'd0);
    assign resp_status = skid_reg[skid_rd_reg][SKID_W-1 -: CFU_STATUS_W];
    assign resp_data   = skid_reg[skid_rd_reg][CFU_DATA_W-1:0];

    // Skid slots and pointers; reset leaves an OK/zero response on the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                skid_reg[i] <= {CFU_OK, {CFU_DATA_W{1'b0}}};
            end
            skid_wr_reg  <= 1'b0;
            skid_rd_reg  <= 1'b0;
            skid_cnt_reg <= 2'd0;
        end else begin
            if (skid_load) begin
                skid_reg[skid_wr_reg] <= {core_status, core_data};
                skid_wr_reg           <= !skid_wr_reg;
            end
            if (skid_unload) begin
                skid_rd_reg <= !skid_rd_reg;
            end
            skid_cnt_reg <= skid_cnt_reg + 2'(skid_load) - 2'(skid_unload);
        end
    end
`else
    // Combinational response path straight from the selected channel
    assign core_ready  = en && resp_ready;
    assign pop         = core_valid && core_ready;
    assign resp_valid  = en && core_valid;
    assign resp_status = core_status;
    assign resp_data   = core_data;
`endif

endmodule

// File: tb/tb_cfu_l2_switch.sv
// Directed self-checking bench for cfu_l2_switch (N=4 channels, 3-bit CFU ID so that
// out-of-range IDs can be driven, 4-deep order FIFO, combinational response path).
module tb_cfu_l2_switch;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int SW = 3;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_cfu;
    logic [0:0]    req_state;
    logic [9:0]    req_func;
    logic [31:0]   req_insn;
    logic [DW-1:0] req_data0;
    logic [DW-1:0] req_data1;
    logic          resp_valid;
    logic          resp_ready;
    logic [SW-1:0] resp_status;
    logic [DW-1:0] resp_data;
    logic [N-1:0]  cfus_req_valid;
    logic [N-1:0]  cfus_req_ready;
    logic [0:0]    cfus_req_state;
    logic [9:0]    cfus_req_func;
    logic [31:0]   cfus_req_insn;
    logic [DW-1:0] cfus_req_data0;
    logic [DW-1:0] cfus_req_data1;
    logic [N-1:0]  cfus_resp_valid;
    logic [N-1:0]  cfus_resp_ready;
    logic [N*SW-1:0] cfus_resp_status;
    logic [N*DW-1:0] cfus_resp_data;

    int total;
    int bad;

    cfu_l2_switch #(
        .CFU_N_CFUS    (N),
        .CFU_CFU_ID_W  (IW),
        .N_OUTSTANDING (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clk_en           (clk_en),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cfu          (req_cfu),
        .req_state        (req_state),
        .req_func         (req_func),
        .req_insn         (req_insn),
        .req_data0        (req_data0),
        .req_data1        (req_data1),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_status      (resp_status),
        .resp_data        (resp_data),
        .cfus_req_valid   (cfus_req_valid),
        .cfus_req_ready   (cfus_req_ready),
        .cfus_req_state   (cfus_req_state),
        .cfus_req_func    (cfus_req_func),
        .cfus_req_insn    (cfus_req_insn),
        .cfus_req_data0   (cfus_req_data0),
        .cfus_req_data1   (cfus_req_data1),
        .cfus_resp_valid  (cfus_resp_valid),
        .cfus_resp_ready  (cfus_resp_ready),
        .cfus_resp_status (cfus_resp_status),
        .cfus_resp_data   (cfus_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks happen 1 time unit later
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic [SW-1:0] st, input logic [DW-1:0] d);
        cfus_resp_status[ch*SW +: SW] = st;
        cfus_resp_data[ch*DW +: DW]   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; clk_en = 1'b1;
        req_valid = 1'b0; req_cfu = '0; req_state = '0; req_func = '0; req_insn = '0;
        req_data0 = '0; req_data1 = '0; resp_ready = 1'b0;
        cfus_req_ready = '0; cfus_resp_valid = '0; cfus_resp_status = '0; cfus_resp_data = '0;

        // ---- reset state (outputs gated while rst is high) ----
        nxt(); nxt();
        req_valid = 1'b1; cfus_req_ready = '1; resp_ready = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cfus_req_valid", cfus_req_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_cfus_resp_ready", cfus_resp_ready, 0);
        chk("rst_resp_status", resp_status, 0);
        chk("rst_resp_data", resp_data, 0);
        nxt();
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; cfus_req_ready = '0;

        // ---- 1: request to CFU 2, answered 3 cycles later ----
        nxt();
        req_valid = 1'b1; req_cfu = 3'd2; cfus_req_ready = 4'b1011;
        req_state = 1'b1; req_func = 10'h2a5; req_insn = 32'h0123_4567;
        req_data0 = 32'hdead_0001; req_data1 = 32'hbeef_0002;
        #1;
        chk("t1_valid_not_ready", cfus_req_valid, 4'b0100);
        chk("t1_req_ready_blocked", req_ready, 0);
        chk("t1_bcast_state", cfus_req_state, 1'b1);
        chk("t1_bcast_func", cfus_req_func, 10'h2a5);
        chk("t1_bcast_insn", cfus_req_insn, 32'h0123_4567);
        chk("t1_bcast_data0", cfus_req_data0, 32'hdead_0001);
        chk("t1_bcast_data1", cfus_req_data1, 32'hbeef_0002);
        nxt();
        cfus_req_ready = 4'b0100;
        #1;
        chk("t1_cfus_req_valid", cfus_req_valid, 4'b0100);
        chk("t1_req_ready", req_ready, 1);
        nxt();
        req_valid = 1'b0; resp_ready = 1'b1;
        #1;
        chk("t1_wait_resp_valid", resp_valid, 0);
        chk("t1_wait_resp_ready", cfus_resp_ready, 4'b0100);
        nxt(); nxt();
        cfus_resp_valid = 4'b0100; set_ch(2, 3'd0, 32'h0000_00a5);
        #1;
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_status", resp_status, 0);
        chk("t1_resp_data", resp_data, 32'h0000_00a5);
        nxt();
        cfus_resp_valid = '0;
        #1;
        chk("t1_after_pop_valid", resp_valid, 0);
        chk("t1_after_pop_ready", cfus_resp_ready, 0);

        // ---- 2: requests to 3 then 0; channel 0 answers first ----
        nxt();
        req_valid = 1'b1; req_cfu = 3'd3; cfus_req_ready = 4'b1111;
        #1;
        chk("t2_req3_valid", cfus_req_valid, 4'b1000);
        nxt();
        req_cfu = 3'd0; cfus_resp_valid = 4'b0001; set_ch(0, 3'd0, 32'h11);
        #1;
        chk("t2_req0_valid", cfus_req_valid, 4'b0001);
        chk("t2_req0_ready", req_ready, 1);
        chk("t2_head3_no_valid", resp_valid, 0);
        chk("t2_ch0_stalled", cfus_resp_ready, 4'b1000);
        nxt();
        req_valid = 1'b0;
        #1;
        chk("t2_ch0_still_stalled", cfus_resp_ready, 4'b1000);
        chk("t2_still_no_valid", resp_valid, 0);
        cfus_resp_valid = 4'b1001; set_ch(3, 3'd0, 32'h33);
        #1;
        chk("t2_first_valid", resp_valid, 1);
        chk("t2_first_data", resp_data, 32'h33);
        chk("t2_first_ready", cfus_resp_ready, 4'b1000);
        nxt();
        cfus_resp_valid = 4'b0001;
        #1;
        chk("t2_second_valid", resp_valid, 1);
        chk("t2_second_data", resp_data, 32'h11);
        chk("t2_second_ready", cfus_resp_ready, 4'b0001);
        nxt();
        cfus_resp_valid = '0;
        #1;
        chk("t2_drained", resp_valid, 0);

        // ---- 3: out-of-range CFU ID answered locally ----
        resp_ready = 1'b0;
        nxt();
        req_valid = 1'b1; req_cfu = 3'd5; cfus_req_ready = 4'b0000;
        #1;
        chk("t3_no_channel", cfus_req_valid, 0);
        chk("t3_req_ready", req_ready, 1);
        nxt();
        req_valid = 1'b0; cfus_resp_valid = 4'b0001; set_ch(0, 3'd2, 32'hdead);
        #1;
        chk("t3_resp_valid", resp_valid, 1);
        chk("t3_resp_status", resp_status, 3'd1);
        chk("t3_resp_data", resp_data, 0);
        chk("t3_no_cfu_ready", cfus_resp_ready, 0);
        resp_ready = 1'b1;
        nxt();
        cfus_resp_valid = '0;
        #1;
        chk("t3_popped", resp_valid, 0);

        // ---- 4: FIFO full after 4 outstanding, no bypass on same-cycle pop ----
        resp_ready = 1'b0; cfus_req_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            nxt();
            req_valid = 1'b1; req_cfu = 3'd1;
            #1;
            chk($sformatf("t4_push%0d_ready", k), req_ready, 1);
        end
        nxt();
        #1;
        chk("t4_full_ready", req_ready, 0);
        chk("t4_full_no_valid", cfus_req_valid, 0);
        cfus_resp_valid = 4'b0010; set_ch(1, 3'd0, 32'h44); resp_ready = 1'b1;
        #1;
        chk("t4_pop_no_bypass", req_ready, 0);
        chk("t4_pop_valid", resp_valid, 1);
        chk("t4_pop_data", resp_data, 32'h44);
        nxt();
        req_valid = 1'b0; cfus_resp_valid = '0; resp_ready = 1'b0;
        #1;
        chk("t4_reenabled", req_ready, 1);

        // ---- 5: reset with 3 in flight ----
        nxt();
        rst = 1'b1;
        #1;
        chk("t5_rst_req_ready", req_ready, 0);
        chk("t5_rst_resp_valid", resp_valid, 0);
        nxt();
        rst = 1'b0; cfus_resp_valid = 4'b0010; resp_ready = 1'b1;
        #1;
        chk("t5_empty_valid", resp_valid, 0);
        chk("t5_empty_ready", cfus_resp_ready, 0);
        req_valid = 1'b1; req_cfu = 3'd2;
        #1;
        chk("t5_new_ready", req_ready, 1);
        chk("t5_new_valid", cfus_req_valid, 4'b0100);
        nxt();
        req_valid = 1'b0; cfus_resp_valid = 4'b0100; set_ch(2, 3'd0, 32'h55);
        #1;
        chk("t5_new_resp_valid", resp_valid, 1);
        chk("t5_new_resp_data", resp_data, 32'h55);
        chk("t5_new_resp_ready", cfus_resp_ready, 4'b0100);
        nxt();
        cfus_resp_valid = '0;
        #1;
        chk("t5_single_entry", resp_valid, 0);

        // ---- 6: clk_en low while head response is pending ----
        resp_ready = 1'b0;
        nxt();
        req_valid = 1'b1; req_cfu = 3'd3;
        #1;
        chk("t6_push_ready", req_ready, 1);
        nxt();
        req_valid = 1'b1; clk_en = 1'b0; resp_ready = 1'b1;
        cfus_resp_valid = 4'b1000; set_ch(3, 3'd0, 32'h66);
        #1;
        chk("t6_off_resp_valid", resp_valid, 0);
        chk("t6_off_resp_ready", cfus_resp_ready, 0);
        chk("t6_off_req_ready", req_ready, 0);
        chk("t6_off_req_valid", cfus_req_valid, 0);
        nxt();
        req_valid = 1'b0;
        #1;
        chk("t6_off_hold", resp_valid, 0);
        nxt();
        clk_en = 1'b1;
        #1;
        chk("t6_resume_valid", resp_valid, 1);
        chk("t6_resume_data", resp_data, 32'h66);
        chk("t6_resume_ready", cfus_resp_ready, 4'b1000);
        nxt();
        cfus_resp_valid = '0;
        #1;
        chk("t6_drained", resp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
